div8by4_seq: RTL and testbench

- Sequential restoring divider; the inverse of the 4x4 composed multipliers.
- Takes an N-bit product/dividend and an M-bit divisor; returns an N-bit quotient and an M-bit remainder.
- Used to check multiplier outputs on silicon: P = A*B, then P / B must give quotient A and remainder 0.
- Sits behind the multiplier datapath with valid/ready handshakes on both sides.

---
 rtl/div8by4_seq.sv | 158 +++++++++++++++
 tb/tb_div8by4_seq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div8by4_seq.sv
// div8by4_seq: sequential restoring divider that produces one quotient bit per cycle,
// MSB first. It is used to read multiplier results back on silicon: P / B must
// return A with a zero remainder.
//
// Parameters:
//   N  dividend / quotient width (N >= 2)
//   M  divisor / remainder width (M <= N)
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     operand valid
//   in_ready     block is idle and can accept an operation
//   dividend     unsigned numerator, sampled only on the accept edge
//   divisor      unsigned denominator, sampled only on the accept edge
//   out_valid    result valid; held until out_ready
//   out_ready    consumer accepts the result
//   quotient     unsigned quotient ({N{1}} on divide-by-zero)
//   remainder    unsigned remainder (dividend[M-1:0] on divide-by-zero)
//   div_by_zero  divisor was zero for this result
module div8by4_seq #(
  parameter int unsigned N = 8,
  parameter int unsigned M = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] dividend,
  input  logic [M-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic [M-1:0] remainder,
  output logic         div_by_zero
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  state_e state_q, state_d;

  // work_q starts as the dividend and is shifted left once per step; quotient bits
  // enter at the bottom, so after N steps it holds the full quotient.
  logic [N-1:0]  work_q, work_d;
  logic [M-1:0]  dvs_q, dvs_d;
  // The partial remainder is always < divisor after a step, so M bits suffice
  // between steps; the widened value only exists inside the step.
  logic [M-1:0]  rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [M-1:0]  remo_q, remo_d;
  logic          dbz_q, dbz_d;

  logic [M:0]    trial;
  logic [M:0]    diff;
  logic          fits;
  logic [M-1:0]  rem_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q <= '0;
      dvs_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      quo_q  <= '0;
      remo_q <= '0;
      dbz_q  <= 1'b0;
    end else begin
      work_q <= work_d;
      dvs_q  <= dvs_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_d;
      quo_q  <= quo_d;
      remo_q <= remo_d;
      dbz_q  <= dbz_d;
    end
  end

  // One restoring step: shift the next dividend bit in, subtract if it fits.
  always_comb begin
    trial    = {rem_q, work_q[N-1]};
    fits     = (trial >= {1'b0, dvs_q});
    diff     = trial - {1'b0, dvs_q};
    // When the subtract is taken the result is < divisor, so bit M is zero.
    rem_step = fits ? diff[M-1:0] : trial[M-1:0];
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          work_d = dividend;
          dvs_d  = divisor;
          rem_d  = '0;
          cnt_d  = '0;
          if (divisor == '0) begin
            quo_d   = '1;
            remo_d  = dividend[M-1:0];
            dbz_d   = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        rem_d  = rem_step;
        work_d = {work_q[N-2:0], fits};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          quo_d   = {work_q[N-2:0], fits};
          remo_d  = rem_step;
          dbz_d   = 1'b0;
          cnt_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign in_ready    = (state_q == StIdle);
  assign out_valid   = (state_q == StDone);
  assign quotient    = quo_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div8by4_seq.sv
// Testbench for div8by4_seq: a driver issues operations and pushes expected results
// into a queue; an independent monitor pops and compares at every output handshake.
module tb_div8by4_seq;

  localparam int unsigned N = 8;
  localparam int unsigned M = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] dividend;
  logic [M-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] quotient;
  logic [M-1:0] remainder;
  logic         div_by_zero;

  typedef struct {
    logic [N-1:0] q;
    logic [M-1:0] r;
    logic         z;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  div8by4_seq #(
    .N(N),
    .M(M)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer division with the divide-by-zero convention.
  function automatic exp_t model(input logic [N-1:0] a, input logic [M-1:0] b);
    exp_t e;
    int   ai;
    int   bi;
    ai = int'(a);
    bi = int'(b);
    if (bi == 0) begin
      e.q = '1;
      e.r = a[M-1:0];
      e.z = 1'b1;
    end else begin
      e.q = N'(ai / bi);
      e.r = M'(ai % bi);
      e.z = 1'b0;
    end
    return e;
  endfunction

  // Monitor: a handshake happens at the next rising edge when both are high here.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected result", 32'(out_valid), 32'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("quotient", 32'(quotient), 32'(e.q));
        chk("remainder", 32'(remainder), 32'(e.r));
        chk("div_by_zero", 32'(div_by_zero), 32'(e.z));
      end
    end
  end

  task automatic run_op(input logic [N-1:0] a, input logic [M-1:0] b, input exp_t e,
                        input int hold, input bit toggle);
    int k;
    k = 0;
    while (!in_ready && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("in_ready before accept", 32'(in_ready), 32'(1));
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    exp_q.push_back(e);
    k = 0;
    while (!out_valid && k < 4 * N) begin
      chk("in_ready while busy", 32'(in_ready), 32'(0));
      if (toggle) begin
        in_valid = 1'($urandom_range(0, 1));
        dividend = N'($urandom);
        divisor  = M'($urandom);
      end
      @(posedge clk);
      #1;
      k++;
    end
    in_valid = 1'b0;
    chk("latency", 32'(k), (b == '0) ? 32'(0) : 32'(N));
    chk("out_valid", 32'(out_valid), 32'(1));
    for (int i = 0; i < hold; i++) begin
      chk("held quotient", 32'(quotient), 32'(e.q));
      chk("held remainder", 32'(remainder), 32'(e.r));
      chk("held div_by_zero", 32'(div_by_zero), 32'(e.z));
      chk("held out_valid", 32'(out_valid), 32'(1));
      chk("in_ready in done", 32'(in_ready), 32'(0));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("out_valid after handshake", 32'(out_valid), 32'(0));
    chk("in_ready after handshake", 32'(in_ready), 32'(1));
  endtask

  function automatic exp_t mk(input logic [N-1:0] q, input logic [M-1:0] r, input logic z);
    exp_t e;
    e.q = q;
    e.r = r;
    e.z = z;
    return e;
  endfunction

  initial begin
    int k;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", 32'(in_ready), 32'(1));
    chk("reset out_valid", 32'(out_valid), 32'(0));
    chk("reset quotient", 32'(quotient), 32'(0));
    chk("reset remainder", 32'(remainder), 32'(0));
    chk("reset div_by_zero", 32'(div_by_zero), 32'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases with expectations written out by hand.
    run_op(8'd200, 4'd13, mk(8'd15, 4'd5, 1'b0), 0, 1'b0);
    run_op(8'd255, 4'd1, mk(8'd255, 4'd0, 1'b0), 0, 1'b0);
    run_op(8'd0, 4'd7, mk(8'd0, 4'd0, 1'b0), 0, 1'b0);
    run_op(8'd15, 4'd15, mk(8'd1, 4'd0, 1'b0), 0, 1'b0);
    run_op(8'd14, 4'd15, mk(8'd0, 4'd14, 1'b0), 0, 1'b0);
    run_op(8'h5A, 4'd0, mk(8'hFF, 4'hA, 1'b1), 0, 1'b0);
    // Backpressure and busy-time noise on the inputs.
    run_op(8'd200, 4'd13, mk(8'd15, 4'd5, 1'b0), 5, 1'b0);
    run_op(8'd173, 4'd6, mk(8'd28, 4'd5, 1'b0), 2, 1'b1);
    run_op(8'h5A, 4'd0, mk(8'hFF, 4'hA, 1'b1), 5, 1'b0);

    // Reset during the 4th CALC cycle aborts the operation.
    dividend = 8'd77;
    divisor  = 4'd5;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort out_valid", 32'(out_valid), 32'(0));
    chk("abort in_ready", 32'(in_ready), 32'(1));
    chk("abort quotient", 32'(quotient), 32'(0));
    chk("abort remainder", 32'(remainder), 32'(0));
    chk("abort div_by_zero", 32'(div_by_zero), 32'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("release in_ready", 32'(in_ready), 32'(1));
    k = 0;
    for (int i = 0; i < N + 4; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) k++;
    end
    chk("stale result cycles", 32'(k), 32'(0));
    run_op(8'd100, 4'd9, mk(8'd11, 4'd1, 1'b0), 0, 1'b0);

    // Multiplier round trip: (A*B)/B == A, remainder 0.
    for (int a = 1; a <= 15; a++) begin
      for (int b = 1; b <= 15; b++) begin
        run_op(N'(a * b), M'(b), mk(N'(a), '0, 1'b0), 0, 1'b0);
      end
    end

    // Random sweep against the reference model.
    for (int i = 0; i < 200; i++) begin
      logic [N-1:0] ra;
      logic [M-1:0] rb;
      ra = N'($urandom);
      rb = M'($urandom_range(0, 15));
      run_op(ra, rb, model(ra, rb), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      @(posedge clk);
      k++;
    end
    chk("scoreboard drained", 32'(exp_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
